// File: rtl/div_seq_pkg.sv
// Shared types and constants for the divider front-end sequencer.
package div_seq_pkg;
  localparam int DATA_W          = 32;
  localparam int ID_W            = 2;
  localparam int DEFAULT_TIMEOUT = 40;
  localparam int WDOG_W          = 6;

  typedef enum logic [1:0] {
    IDLE,
    LAUNCH,
    WAIT,
    RESP
  } state_t;
endpackage

// File: rtl/div_sequencer_rr_arbiter.sv
// Round-robin arbiter: grants the first valid requester at or after ptr,
// wrapping modulo NUM_REQ. Purely combinational; the pointer lives in the caller.
module rr_arbiter
  import div_seq_pkg::*;
#(
  parameter int NUM_REQ = 2
) (
  input  logic [NUM_REQ-1:0] valid,
  input  logic [ID_W-1:0]    ptr,
  input  logic               enable,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    idx,
  output logic               any
);

  // Search from ptr upward first, then wrap to the low indices below ptr.
  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (enable && !any && valid[i] && (i >= int'(ptr))) begin
        grant[i] = 1'b1;
        idx      = ID_W'(i);
        any      = 1'b1;
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (enable && !any && valid[i]) begin
        grant[i] = 1'b1;
        idx      = ID_W'(i);
        any      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/div_sequencer.sv
// Front-end controller for the shared iterative signed divider.
// Optional build macro DIV_SEQ_FASTPATH_EN: divisors 0 and 1 are answered
// directly from IDLE without starting the divider.
module div_sequencer
  import div_seq_pkg::*;
#(
  parameter int NUM_REQ     = 2,
  parameter int DIV_TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic                        clock,
  input  logic                        reset_n,
  input  logic [NUM_REQ-1:0]          req_valid,
  input  logic [DATA_W*NUM_REQ-1:0]   req_opA,
  input  logic [DATA_W*NUM_REQ-1:0]   req_opB,
  output logic [NUM_REQ-1:0]          req_ready,
  output logic                        rsp_valid,
  input  logic                        rsp_ready,
  output logic [ID_W-1:0]             rsp_id,
  output logic signed [DATA_W-1:0]    rsp_result,
  output logic                        rsp_exception,
  output logic                        busy,
  output logic signed [DATA_W-1:0]    div_opA,
  output logic signed [DATA_W-1:0]    div_opB,
  output logic                        div_ctrl,
  input  logic signed [DATA_W-1:0]    div_result,
  input  logic                        div_exception,
  input  logic                        div_rdy
);

  state_t                   state, state_n;
  logic [ID_W-1:0]          ptr;
  logic [WDOG_W-1:0]        wdog;
  logic [NUM_REQ-1:0]       grant;
  logic [ID_W-1:0]          gnt_idx;
  logic                     gnt_any;
  logic signed [DATA_W-1:0] sel_a, sel_b;
  logic                     rdy_ok, timeout, fast_hit;
  logic [ID_W-1:0]          ptr_nxt;

  // Arbitration is only enabled in IDLE and never while reset is held.
  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .valid  (req_valid),
    .ptr    (ptr),
    .enable ((state == IDLE) && reset_n),
    .grant  (grant),
    .idx    (gnt_idx),
    .any    (gnt_any)
  );

  assign req_ready = grant;
  assign rsp_valid = (state == RESP);
  assign busy      = (state != IDLE);
  assign ptr_nxt   = (gnt_idx == ID_W'(NUM_REQ - 1)) ? '0 : gnt_idx + ID_W'(1);

  // First WAIT cycle has wdog==0; a high rdy there is left over from the previous run.
  assign rdy_ok  = div_rdy && (wdog != '0);
  assign timeout = (wdog == WDOG_W'(DIV_TIMEOUT - 1));

`ifdef DIV_SEQ_FASTPATH_EN
  assign fast_hit = (sel_b == 32'sd0) || (sel_b == 32'sd1);
`else
  assign fast_hit = 1'b0;
`endif

  // Operand mux for the granted requester.
  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt_idx == ID_W'(i)) begin
        sel_a = req_opA[i*DATA_W +: DATA_W];
        sel_b = req_opB[i*DATA_W +: DATA_W];
      end
    end
  end

  // Next-state decode.
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (gnt_any) state_n = fast_hit ? RESP : LAUNCH;
      LAUNCH:  state_n = WAIT;
      WAIT:    if (rdy_ok || timeout) state_n = RESP;
      RESP:    if (rsp_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_n;
  end

  // Operand latch, watchdog, result capture and the registered start pulse.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ptr           <= '0;
      wdog          <= '0;
      div_opA       <= '0;
      div_opB       <= '0;
      div_ctrl      <= 1'b0;
      rsp_id        <= '0;
      rsp_result    <= '0;
      rsp_exception <= 1'b0;
    end else begin
      div_ctrl <= (state_n == LAUNCH);
      case (state)
        IDLE: begin
          if (gnt_any) begin
            div_opA <= sel_a;
            div_opB <= sel_b;
            rsp_id  <= gnt_idx;
            ptr     <= ptr_nxt;
            if (fast_hit) begin
              rsp_result    <= (sel_b == 32'sd0) ? '0 : sel_a;
              rsp_exception <= (sel_b == 32'sd0);
            end
          end
        end
        LAUNCH: wdog <= '0;
        WAIT: begin
          wdog <= wdog + WDOG_W'(1);
          if (rdy_ok) begin
            rsp_result    <= div_result;
            rsp_exception <= div_exception;
          end else if (timeout) begin
            rsp_result    <= '0;
            rsp_exception <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_div_sequencer.sv
// Scoreboard bench for div_sequencer with a behavioural iterative divider.
module tb_div_sequencer;
  localparam int NREQ = 2;
  localparam int TMO  = 40;

  logic                      clock = 1'b0;
  logic                      reset_n = 1'b0;
  logic [NREQ-1:0]           req_valid;
  logic [32*NREQ-1:0]        req_opA, req_opB;
  logic [NREQ-1:0]           req_ready;
  logic                      rsp_valid, rsp_ready;
  logic [1:0]                rsp_id;
  logic signed [31:0]        rsp_result;
  logic                      rsp_exception, busy;
  logic signed [31:0]        div_opA, div_opB;
  logic                      div_ctrl;
  logic signed [31:0]        div_result;
  logic                      div_exception, div_rdy;

  div_sequencer #(.NUM_REQ(NREQ), .DIV_TIMEOUT(TMO)) dut (
    .clock(clock), .reset_n(reset_n),
    .req_valid(req_valid), .req_opA(req_opA), .req_opB(req_opB), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_result(rsp_result), .rsp_exception(rsp_exception), .busy(busy),
    .div_opA(div_opA), .div_opB(div_opB), .div_ctrl(div_ctrl),
    .div_result(div_result), .div_exception(div_exception), .div_rdy(div_rdy)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [1:0]  id;
    logic [31:0] res;
    logic        exc;
  } exp_t;

  exp_t sbq[$];
  exp_t e;
  int checks = 0, errors = 0;
  int cyc = 0;
  int last_acc = -1, last_ctrl = -1, rsp_start = -1, last_hs = -1, ctrl_cnt = 0;
  logic prev_rv = 1'b0;

  // Divider model: rdy m_lat cycles after the start pulse (0 = never); stale rdy
  // from the previous run persists through the first cycle after the pulse.
  int m_lat = 33;
  int m_cnt = 0;
  logic m_run = 1'b0;
  logic signed [31:0] ma, mb;

  always @(posedge clock) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [1:0] id, input int res, input logic exc);
    exp_t x;
    x.id = id; x.res = res; x.exc = exc;
    sbq.push_back(x);
  endtask

  always @(negedge clock) begin
    if (div_ctrl) begin
      m_cnt = 0; m_run = 1'b1; ma = div_opA; mb = div_opB;
    end else if (m_run) begin
      m_cnt++;
      if (m_cnt == 1) div_rdy = 1'b0;
      if (m_lat != 0 && m_cnt == m_lat) begin
        div_rdy = 1'b1;
        m_run   = 1'b0;
        if (mb == 0) begin div_result = '0; div_exception = 1'b1; end
        else begin div_result = ma / mb; div_exception = 1'b0; end
      end
    end
  end

  // Monitor: event timestamps and scoreboard pop on every response handshake.
  always @(negedge clock) begin
    if (reset_n) begin
      if (|(req_valid & req_ready)) last_acc = cyc;
      if (div_ctrl) begin last_ctrl = cyc; ctrl_cnt++; end
      if (rsp_valid && !prev_rv) rsp_start = cyc;
      if (rsp_valid && rsp_ready) begin
        last_hs = cyc;
        if (sbq.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_rsp: got id %0d result %0h, required no response", rsp_id, rsp_result);
        end else begin
          e = sbq.pop_front();
          chk("rsp_id", {30'b0, rsp_id}, {30'b0, e.id});
          chk("rsp_result", rsp_result, e.res);
          chk("rsp_exception", {31'b0, rsp_exception}, {31'b0, e.exc});
        end
      end
    end
    prev_rv = rsp_valid;
  end

  task automatic sync();
    @(posedge clock); #1;
  endtask

  task automatic set_req(input int i, input int a, input int b);
    req_opA[i*32 +: 32] = a;
    req_opB[i*32 +: 32] = b;
    req_valid[i] = 1'b1;
  endtask

  // Hold the masked requests until each one is accepted.
  task automatic serve(input logic [NREQ-1:0] m);
    logic [NREQ-1:0] acc;
    int n = 0;
    while (((req_valid & m) != '0) && n < 300) begin
      @(negedge clock); #1;
      acc = req_valid & req_ready;
      @(posedge clock); #1;
      req_valid = req_valid & ~acc;
      n++;
    end
    if (n >= 300) begin
      checks++; errors++;
      $display("FAIL accept_timeout: got valid %b still pending, required accepted", req_valid);
      req_valid = '0;
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    do begin
      @(negedge clock); #1; n++;
    end while ((busy || rsp_valid) && n < 300);
    if (n >= 300) begin
      checks++; errors++;
      $display("FAIL idle_timeout: got busy %0b, required 0", busy);
    end
  endtask

  int c0;

  initial begin
    req_valid = '0; req_opA = '0; req_opB = '0; rsp_ready = 1'b1;
    div_rdy = 1'b0; div_result = '0; div_exception = 1'b0;

    // Both requesters valid while reset is held.
    set_req(0, -50, 5);
    set_req(1, 9, 3);
    repeat (3) @(posedge clock);
    #1;
    chk("reset_busy", {31'b0, busy}, 32'd0);
    chk("reset_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    chk("reset_div_ctrl", {31'b0, div_ctrl}, 32'd0);
    chk("reset_req_ready", {30'b0, req_ready}, 32'd0);
    chk("reset_rsp_id", {30'b0, rsp_id}, 32'd0);
    chk("reset_div_opA", div_opA, 32'd0);
    reset_n = 1'b1;
    push(2'd0, -10, 1'b0);
    push(2'd1, 3, 1'b0);
    serve(2'b11);
    wait_idle();

    // Single request on requester 0 with a 33-cycle divider.
    sync();
    c0 = ctrl_cnt;
    push(2'd0, 14, 1'b0);
    set_req(0, 100, 7);
    serve(2'b01);
    @(negedge clock); #1;
    chk("opA_latched", div_opA, 32'd100);
    wait_idle();
    chk("acc_to_ctrl", last_ctrl - last_acc, 32'd1);
    chk("ctrl_to_rsp", rsp_start - last_ctrl, 32'd34);
    chk("ctrl_pulses", ctrl_cnt - c0, 32'd1);

    // Fresh pair after a requester-0 grant: requester 1 goes first.
    sync();
    push(2'd1, -4, 1'b0);
    push(2'd0, 5, 1'b0);
    set_req(0, 20, 4);
    set_req(1, -9, 2);
    serve(2'b11);
    wait_idle();

    // Divide by zero.
    sync();
    c0 = ctrl_cnt;
    push(2'd0, 0, 1'b1);
    set_req(0, 5, 0);
    serve(2'b01);
    wait_idle();
`ifdef DIV_SEQ_FASTPATH_EN
    chk("fast_zero_lat", rsp_start - last_acc, 32'd1);
    chk("fast_zero_noctrl", ctrl_cnt - c0, 32'd0);
`else
    chk("zero_ctrl", ctrl_cnt - c0, 32'd1);
`endif

    // Divide by one.
    sync();
    c0 = ctrl_cnt;
    push(2'd1, -77, 1'b0);
    set_req(1, -77, 1);
    serve(2'b10);
    wait_idle();
`ifdef DIV_SEQ_FASTPATH_EN
    chk("fast_one_lat", rsp_start - last_acc, 32'd1);
    chk("fast_one_noctrl", ctrl_cnt - c0, 32'd0);
`else
    chk("one_ctrl", ctrl_cnt - c0, 32'd1);
`endif

    // Divider never answers: watchdog forces an exception.
    sync();
    m_lat = 0;
    push(2'd0, 0, 1'b1);
    set_req(0, 6, 3);
    serve(2'b01);
    wait_idle();
    chk("timeout_lat", rsp_start - last_ctrl, TMO + 1);
    m_lat = 33;

    // Back-pressure on the response while requester 1 waits.
    sync();
    rsp_ready = 1'b0;
    push(2'd0, -7, 1'b0);
    set_req(0, 63, -8);
    serve(2'b01);
    set_req(1, 9, 3);
    begin
      int n = 0;
      do begin @(negedge clock); #1; n++; end while (!rsp_valid && n < 100);
      if (n >= 100) begin
        checks++; errors++;
        $display("FAIL stall_rsp_timeout: got rsp_valid 0, required 1");
      end
    end
    for (int k = 0; k < 5; k++) begin
      chk("stall_req_ready", {30'b0, req_ready}, 32'd0);
      chk("stall_rsp_id", {30'b0, rsp_id}, 32'd0);
      chk("stall_rsp_result", rsp_result, -32'sd7);
      chk("stall_rsp_valid", {31'b0, rsp_valid}, 32'd1);
      @(negedge clock); #1;
    end
    sync();
    rsp_ready = 1'b1;
    push(2'd1, 3, 1'b0);
    serve(2'b10);
    chk("bubble_after_hs", last_acc - last_hs, 32'd1);
    wait_idle();

    // Reset pulsed while the divider is running.
    sync();
    set_req(0, 100, 10);
    serve(2'b01);
    repeat (6) @(negedge clock);
    @(posedge clock); #2;
    reset_n = 1'b0;
    #1;
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    chk("rst_div_opA", div_opA, 32'd0);
    chk("rst_div_opB", div_opB, 32'd0);
    chk("rst_rsp_id", {30'b0, rsp_id}, 32'd0);
    chk("rst_rsp_result", rsp_result, 32'd0);
    chk("rst_div_ctrl", {31'b0, div_ctrl}, 32'd0);
    repeat (2) @(posedge clock);
    #1;
    reset_n = 1'b1;
    sync();
    push(2'd0, 4, 1'b0);
    set_req(0, 8, 2);
    serve(2'b01);
    wait_idle();
    repeat (3) @(negedge clock);

    chk("scoreboard_empty", sbq.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/div_sequencer.md
# div_sequencer

Front-end controller for the shared iterative 32-bit signed divider in the processor's multdiv path. Arbitrates among up to NUM_REQ requesters (round-robin), latches the chosen operands, and holds them stable for the divider's whole run. Issues the one-cycle start pulse, waits for the ready flag, and returns quotient, exception flag and requester ID over a valid/ready response channel. A watchdog bounds every operation.

## Interface
Parameters:
- NUM_REQ, 2: number of requesters (2..4).
- DIV_TIMEOUT, 40: maximum cycles in WAIT before forced exception.

Ports:
- clock  in  1  single clock; all state on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- req_valid  in  NUM_REQ  per-requester request.
- req_opA  in  32*NUM_REQ  dividends, requester i at [32i+31:32i].
- req_opB  in  32*NUM_REQ  divisors, same packing.
- req_ready  out  NUM_REQ  one-hot accept; handshake when valid&ready.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  consumer accepts response.
- rsp_id  out  2  index of requester owning the response.
- rsp_result  out  32  signed quotient.
- rsp_exception  out  1  divide-by-zero, divider overflow or timeout.
- busy  out  1  high in any state other than IDLE.
- div_opA, div_opB  out  32  operands to divider, held from accept until response.
- div_ctrl  out  1  divider start pulse.
- div_result  in  32  divider quotient.
- div_exception  in  1  divider exception.
- div_rdy  in  1  divider result ready.

## Operation
- States: IDLE, LAUNCH, WAIT, RESP.
- IDLE: if any req_valid, the arbiter picks the first valid requester at or after ptr (modulo NUM_REQ). req_ready is asserted for that requester only, in the same cycle. opA/opB/id are latched. ptr becomes grant+1. Next state is LAUNCH.
- With no valid requester, req_ready is all zero.
- LAUNCH: div_ctrl=1 for exactly this cycle. Clear the watchdog. Go to WAIT.
- WAIT: increment the watchdog each cycle. div_rdy is ignored on the first WAIT cycle, because stale RDY from a prior run may still be high.
- WAIT, from the second cycle: on div_rdy, capture div_result and div_exception, then go to RESP.
- WAIT timeout: when the watchdog reaches DIV_TIMEOUT with no rdy, capture result=0 and exception=1, then go to RESP.
- RESP: rsp_valid=1. rsp_id, rsp_result and rsp_exception stay stable until rsp_ready. On rsp_valid&rsp_ready, go to IDLE.
- No request is accepted outside IDLE. There is always one bubble between a response handshake and the next accept.
- req_ready never depends on rsp_ready.
- Reset values: state IDLE, ptr 0, all outputs 0 (rsp_id 0, div_opA/B 0, div_ctrl 0).
- Reset mid-operation: abort immediately and drop any pending response. The divider restarts cleanly on the next div_ctrl.

## Timing
- Accept to div_ctrl: 1 cycle.
- div_ctrl to RESP: divider latency (about 33 cycles) plus 1 capture cycle.
- div_ctrl to forced RESP on timeout: DIV_TIMEOUT+1 cycles.
- Fast path (when compiled in): accept to rsp_valid in 1 cycle.
- div_opA/div_opB are registered and change only on an accept edge.
- div_ctrl is registered and decoded from state==LAUNCH.
- Simultaneous valid on several requesters: one grant per accept. A requester not granted keeps valid high and is served in rotation. No starvation: worst-case wait is NUM_REQ-1 full operations.

## Configuration
- DIV_SEQ_FASTPATH_EN defined: in IDLE, an accepted request with opB==0 goes straight to RESP with result=0, exception=1. opB==1 goes to RESP with result=opA, exception=0. In both cases LAUNCH/WAIT are skipped and div_ctrl stays low.
- DIV_SEQ_FASTPATH_EN undefined: every request goes through LAUNCH/WAIT. Divide-by-zero is reported via div_exception.

## Structure
- Package div_seq_pkg:
  - state enum (IDLE, LAUNCH, WAIT, RESP);
  - DATA_W=32;
  - ID_W=2;
  - DEFAULT_TIMEOUT=40;
  - watchdog width constant (6 bits).
- Sub-module rr_arbiter: parameterised NUM_REQ round-robin arbiter. Inputs: valid vector, ptr, enable. Output: one-hot grant plus encoded index.

## Test plan
- Single request, req 0, A=100, B=7; divider model returns rdy after 33 cycles -> one LAUNCH pulse, rsp_result=14, rsp_id=0, exception=0.
- Both requesters valid from reset, req0 A=-50 B=5, req1 A=9 B=3 -> req0 served first (result -10), then req1 (result 3). Following fresh pair -> req1 granted first.
- B=0 -> with DIV_SEQ_FASTPATH_EN: rsp_valid 1 cycle after accept, result 0, exception 1, no div_ctrl. Without it: div_ctrl pulses and the model's exception is forwarded.
- Model never asserts rdy -> rsp_valid with exception=1, result 0, exactly DIV_TIMEOUT+1 cycles after div_ctrl.
- rsp_ready held low 5 cycles while requester 1 is valid -> response fields stable, req_ready stays 0 until the handshake, then req1 accepted one cycle later.
- reset_n pulsed low during WAIT -> all outputs 0 asynchronously. After release, a new request A=8, B=2 returns 4 correctly.
